// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared instruction field positions, the bubble encoding and
//                the scoreboard slot type used by the issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int ALUOP_MSB   = 31;
    localparam int ALUOP_LSB   = 29;
    localparam int DATASRC_BIT = 28;
    localparam int WE_BIT      = 27;
    localparam int WSEL_MSB    = 26;
    localparam int WSEL_LSB    = 22;
    localparam int RSEL1_MSB   = 21;
    localparam int RSEL1_LSB   = 17;
    localparam int RSEL2_MSB   = 16;
    localparam int RSEL2_LSB   = 12;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } sb_slot_t;

endpackage
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : issue_fifo
//  Description : DEPTH x 32 circular instruction buffer with push, pop,
//                flush and occupancy count. Flush wins over push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage write; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (push && !pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (pop && !push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_issue_ctrl
//  Description : Issue controller for the three-stage ALU pipeline. Queues
//                producer instructions, tracks in-flight writes in a shift
//                register scoreboard and inserts zero bubbles on RAW hazards.
//                Optional macro ISSUE_PERF_EN enables the issued / bubble
//                performance counters; otherwise they read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [31:0]              instr_out,
    output logic                     instr_valid,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [31:0]              issued_cnt,
    output logic [31:0]              bubble_cnt
);

    import pipeline_pkg::*;

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int SB_SLOTS = (WB_LAT > 1) ? (WB_LAT - 1) : 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [31:0]   w_head;
    logic [CW-1:0] w_count;
    logic          w_nonempty;
    logic          w_hazard;
    logic          w_pop;
    logic          w_push;
    logic [4:0]    w_src1;
    logic [4:0]    w_src2;
    logic          w_use2;
    sb_slot_t      w_sb_in;

    issue_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_instr),
        .pop       (w_pop),
        .flush     (flush),
        .head      (w_head),
        .count     (w_count)
    );

    assign w_nonempty = (w_count != '0);
    assign w_src1     = w_head[RSEL1_MSB:RSEL1_LSB];
    assign w_src2     = w_head[RSEL2_MSB:RSEL2_LSB];
    // With an immediate operand bits [16:12] are immediate data, not a source.
    assign w_use2     = !w_head[DATASRC_BIT];

    // A flush cycle always issues a bubble, even with a hazard-free head.
    assign w_pop    = w_nonempty && !w_hazard && !flush;
    assign in_ready = !rst && !flush && ((w_count < c_depth) || w_pop);
    assign w_push   = in_valid && in_ready;
    assign stall    = w_nonempty && w_hazard;
    assign q_count  = w_count;

    // Slot 0 records the write of whatever is issued this cycle (bubble = none).
    always_comb begin
        w_sb_in.valid = w_pop && w_head[WE_BIT];
        w_sb_in.addr  = w_pop ? w_head[WSEL_MSB:WSEL_LSB] : 5'd0;
    end

    generate
        if (WB_LAT > 1) begin : g_sb
            sb_slot_t r_sb [SB_SLOTS];

            // Scoreboard shift register; flush leaves it intact on purpose.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SB_SLOTS; i++) begin
                        r_sb[i] <= '0;
                    end
                end else begin
                    r_sb[0] <= w_sb_in;
                    for (int i = 1; i < SB_SLOTS; i++) begin
                        r_sb[i] <= r_sb[i-1];
                    end
                end
            end

            // Head is blocked if any live slot targets one of its sources.
            always_comb begin
                w_hazard = 1'b0;
                for (int i = 0; i < SB_SLOTS; i++) begin
                    if (r_sb[i].valid &&
                        ((r_sb[i].addr == w_src1) ||
                         (w_use2 && (r_sb[i].addr == w_src2)))) begin
                        w_hazard = 1'b1;
                    end
                end
            end
        end else begin : g_no_sb
            // Single-cycle writeback: a consumer may follow its producer directly.
            assign w_hazard = 1'b0;
        end
    endgenerate

    // Registered pipeline instruction port; bubbles are all-zero words.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            instr_out   <= w_pop ? w_head : NOP_INSTR;
            instr_valid <= w_pop;
        end
    end

`ifdef ISSUE_PERF_EN
    logic [31:0] r_issued_cnt;
    logic [31:0] r_bubble_cnt;

    // Free-running wrapping performance counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued_cnt <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else begin
            if (w_pop) begin
                r_issued_cnt <= r_issued_cnt + 32'h1;
            end
            if (stall) begin
                r_bubble_cnt <= r_bubble_cnt + 32'h1;
            end
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign issued_cnt = 32'h0;
    assign bubble_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
